truth_table_checker: RTL
========================

// Module: truth_table_checker
// PURPOSE
//   Self-contained sweep-and-check engine for small combinational blocks under test.
//   Drives every input vector 0..2^N_IN-1 onto the DUT inputs and holds each one for SETTLE cycles.
//   Samples the DUT's single output on the last cycle of each hold window.
//   Compares each sample against the expected truth table EXP_TT and reports error count,
//   first failing vector, the captured output table and an overall pass flag.
// PARAMETERS
//   N_IN    3      number of DUT inputs; vec[N_IN-1] is the MSB (A), vec[0] is the LSB (C)
//   EXP_TT  8'hEA  expected truth table, 2^N_IN bits; bit i = expected y for vec==i (default: Y = A&B | C)
//   SETTLE  4      cycles each vector is held, >=1; y_in is sampled on the final cycle of the hold
// PORTS
//   clk               in   1         single clock, rising-edge
//   rst               in   1         synchronous, active-high reset
//   start             in   1         begin a sweep; honoured only in IDLE or DONE
//   vec               out  N_IN      stimulus vector to the DUT inputs
//   y_in              in   1         DUT output under check
//   busy              out  1         high while a sweep is in progress
//   done              out  1         level; high from sweep end until next start or rst
//   pass              out  1         valid when done=1; 1 iff err_cnt==0
//   err_cnt           out  N_IN+1    number of mismatching vectors (max 2^N_IN, never wraps)
//   first_fail_valid  out  1         set on the first mismatch of the sweep
//   first_fail_vec    out  N_IN      vector index of the first mismatch
//   captured          out  2^N_IN    observed y per vector; bit i written when vec==i is sampled
// BEHAVIOUR
//   Reset: one clk edge with rst=1 forces IDLE. Every output resets to 0
//     (vec, busy, done, pass, err_cnt, first_fail_*, captured). rst has priority over start.
//   FSM states: IDLE, RUN, DONE. All outputs are registered.
//   IDLE/DONE + start=1:
//     - next cycle: RUN, busy=1, done=0, pass=0, vec=0, hold counter=0.
//     - err_cnt, first_fail_*, captured all cleared in that same edge.
//   RUN:
//     - Hold counter counts 0..SETTLE-1.
//     - On the edge where counter==SETTLE-1:
//       - captured[vec] <= y_in.
//       - If y_in != EXP_TT[vec]: err_cnt increments. If first_fail_valid==0,
//         first_fail_vec <= vec and first_fail_valid <= 1.
//       - If vec != 2^N_IN-1: vec increments and the counter returns to 0.
//       - Otherwise: go to DONE, busy=0, done=1, pass = (final err_cnt == 0).
//         pass includes the last vector's result.
//   Timing: vec changes exactly every SETTLE cycles. busy stays high for 2^N_IN*SETTLE cycles.
//     done rises on the edge after the last sample window. Default sweep = 32 cycles.
//   start while RUN: ignored; the sweep is not restarted or perturbed.
//   DONE: results and vec (= 2^N_IN-1) held stable until start or rst.
//   rst mid-sweep: the sweep is abandoned and all results are cleared. The next start sweeps from vec 0.
//   err_cnt is N_IN+1 bits wide, so a fully failing sweep reports exactly 2^N_IN with no saturation logic.
// TESTING
//   1 Golden DUT (Y=A&B|C), rst then start -> busy for 32 cycles, done=1, pass=1,
//     err_cnt=0, captured=8'hEA, first_fail_valid=0.
//   2 y_in stuck at 0 -> err_cnt=5, first_fail_vec=3'd1, first_fail_valid=1,
//     captured=8'h00, pass=0.
//   3 y_in = ~golden -> err_cnt=8 (4'b1000), first_fail_vec=0, captured=8'h15, pass=0.
//   4 start re-pulsed at cycle 10 of a run -> ignored, results identical to test 1.
//     start pulsed in DONE -> one cycle later done=0, err_cnt=0, captured=0, vec=0.
//   5 rst asserted while vec=3 -> next edge: all outputs 0, IDLE.
//     A following start -> full 32-cycle sweep from vec 0.
//   6 SETTLE=1, DUT wrong only at vec 7 -> sweep of 8 cycles, err_cnt=1,
//     first_fail_vec=7, pass=0. vec advances every cycle.

Source files
------------

// File: rtl/truth_table_checker.sv
// truth_table_checker: sweeps every input vector 0..2^N_IN-1 onto a small combinational
// block, holds each vector for SETTLE cycles and samples the block's output on the last
// cycle of each hold. Each sample is compared against EXP_TT. The block reports the
// error count, the first failing vector, the captured output table and a pass flag.
//
// Ports:
//   clk              rising-edge clock
//   rst              synchronous active-high reset; clears every output
//   start            begins a sweep (honoured only when idle or done)
//   vec              stimulus vector driven to the block under test
//   y_in             output of the block under test
//   busy             high while a sweep is in progress
//   done             level, high from sweep end until the next start or rst
//   pass             valid while done; 1 iff err_cnt == 0
//   err_cnt          number of mismatching vectors
//   first_fail_valid set once the first mismatch of a sweep is seen
//   first_fail_vec   vector index of the first mismatch
//   captured         observed output per vector, bit i for vec == i
module truth_table_checker #(
  parameter int unsigned           N_IN   = 3,
  parameter logic [2**N_IN-1:0]    EXP_TT = 'hEA,
  parameter int unsigned           SETTLE = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic [N_IN-1:0]     vec,
  input  logic                y_in,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [N_IN:0]       err_cnt,
  output logic                first_fail_valid,
  output logic [N_IN-1:0]     first_fail_vec,
  output logic [2**N_IN-1:0]  captured
);

  localparam int unsigned CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state;
  logic [CW-1:0]   cnt;
  logic            last_hold;
  logic            mismatch;
  logic [N_IN:0]   err_nxt;

  always_comb begin
    last_hold = (cnt == CW'(SETTLE - 1));
    mismatch  = (y_in != EXP_TT[vec]);
    // Count including the current sample, so pass covers the last vector.
    err_nxt   = err_cnt + (N_IN+1)'(mismatch);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= StIdle;
      cnt              <= '0;
      vec              <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      err_cnt          <= '0;
      first_fail_valid <= 1'b0;
      first_fail_vec   <= '0;
      captured         <= '0;
    end else begin
      unique case (state)
        StIdle, StDone: begin
          if (start) begin
            state            <= StRun;
            cnt              <= '0;
            vec              <= '0;
            busy             <= 1'b1;
            done             <= 1'b0;
            pass             <= 1'b0;
            err_cnt          <= '0;
            first_fail_valid <= 1'b0;
            first_fail_vec   <= '0;
            captured         <= '0;
          end
        end
        StRun: begin
          if (last_hold) begin
            captured[vec] <= y_in;
            err_cnt       <= err_nxt;
            if (mismatch && !first_fail_valid) begin
              first_fail_valid <= 1'b1;
              first_fail_vec   <= vec;
            end
            if (vec != N_IN'(2**N_IN - 1)) begin
              vec <= vec + N_IN'(1);
              cnt <= '0;
            end else begin
              // Final vector sampled: vec stays at the last index while done.
              state <= StDone;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (err_nxt == '0);
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
